updown_counter_gray: RTL and testbench

Parametrised n-bit up/down counter with enable, programmable modulus, wrap or saturate mode, simultaneous binary and Gray-coded registered outputs, terminal-count and sticky overflow flags. It is the next generation of the team's binary up/down counter:
- synchronous clear and preset are retained;
- preset data may be supplied in binary or Gray code.

It feeds Gray-coded pointers and position counters into downstream logic that samples the count without a binary-to-Gray stage of its own.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/gray2bin.sv | 13 +
 rtl/updown_counter_gray.sv | 88 ++++++++
 tb/tb_updown_counter_gray.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: wrap/saturate mode constants and
// binary/Gray conversion helpers (32-bit wide; callers size-cast to their width).
package counter_pkg;

  localparam int CNT_SAT  = 0;
  localparam int CNT_WRAP = 1;
  localparam int CONV_W   = 32;

  function automatic logic [CONV_W-1:0] bin_to_gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [CONV_W-1:0] gray_to_bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// N-bit combinational Gray-to-binary converter: bin[i] is the XOR of gray[N-1:i].
module gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/updown_counter_gray.sv
// Up/down counter with programmable modulus, wrap or saturate, registered binary
// and Gray outputs, combinational terminal count and a sticky boundary flag.
module updown_counter_gray
  import counter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX       = (1 << N) - 1,
  parameter int WRAP      = CNT_WRAP,
  parameter int LOAD_GRAY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         preset,
  input  logic         en,
  input  logic         up_down,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         tc,
  output logic         ovf
);

  localparam logic [N-1:0] MAX_V   = MAX[N-1:0];
  localparam bit           DO_WRAP = (WRAP != CNT_SAT);

  logic [N-1:0] load_bin;
  logic [N-1:0] load_val;
  logic [N-1:0] bin_next;
  logic [N-1:0] gray_next;
  logic         ovf_next;

  if (LOAD_GRAY != 0) begin : g_gray_load
    gray2bin #(.N(N)) u_gray2bin (
      .gray (d_in),
      .bin  (load_bin)
    );
  end else begin : g_bin_load
    assign load_bin = d_in;
  end

  assign load_val = (load_bin > MAX_V) ? MAX_V : load_bin;

  // Boundaries are tested against MAX, so plain N-bit +/-1 never overflows.
  always_comb begin
    bin_next = bin_out;
    ovf_next = ovf;
    if (clear) begin
      bin_next = '0;
      ovf_next = 1'b0;
    end else if (preset) begin
      bin_next = load_val;
    end else if (en) begin
      if (up_down) begin
        if (bin_out == MAX_V) begin
          bin_next = DO_WRAP ? '0 : MAX_V;
          ovf_next = 1'b1;
        end else begin
          bin_next = bin_out + N'(1);
        end
      end else begin
        if (bin_out == '0) begin
          bin_next = DO_WRAP ? MAX_V : '0;
          ovf_next = 1'b1;
        end else begin
          bin_next = bin_out - N'(1);
        end
      end
    end
  end

  assign gray_next = N'(bin_to_gray(CONV_W'(bin_next)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      ovf      <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      ovf      <= ovf_next;
    end
  end

  assign tc = up_down ? (bin_out == MAX_V) : (bin_out == '0);

endmodule

// File: tb/tb_updown_counter_gray.sv
// Self-checking bench: four counter configurations share one stimulus stream and
// are compared against an arithmetic reference model of the counting rules.
module tb_updown_counter_gray;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, preset, en, up_down;
  logic [3:0] d_in;

  logic [3:0] bin_o[4];
  logic [3:0] gray_o[4];
  logic       tc_o[4];
  logic       ovf_o[4];

  // Instance 0: N=4 full range wrap; 1: MAX=9 wrap; 2: MAX=9 saturate; 3: MAX=9 wrap, Gray load
  int mmax[4]  = '{15, 9, 9, 9};
  int mwrap[4] = '{1, 1, 0, 1};
  int mlg[4]   = '{0, 0, 0, 1};
  int mcnt[4];
  bit movf[4];

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  updown_counter_gray #(.N(4)) u_full (
    .clk(clk), .rst_n(rst_n), .clear(clear), .preset(preset), .en(en), .up_down(up_down),
    .d_in(d_in), .bin_out(bin_o[0]), .gray_out(gray_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
  updown_counter_gray #(.N(4), .MAX(9), .WRAP(1), .LOAD_GRAY(0)) u_mod9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .preset(preset), .en(en), .up_down(up_down),
    .d_in(d_in), .bin_out(bin_o[1]), .gray_out(gray_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
  updown_counter_gray #(.N(4), .MAX(9), .WRAP(0), .LOAD_GRAY(0)) u_sat9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .preset(preset), .en(en), .up_down(up_down),
    .d_in(d_in), .bin_out(bin_o[2]), .gray_out(gray_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));
  updown_counter_gray #(.N(4), .MAX(9), .WRAP(1), .LOAD_GRAY(1)) u_gray9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .preset(preset), .en(en), .up_down(up_down),
    .d_in(d_in), .bin_out(bin_o[3]), .gray_out(gray_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3]));

  // ---------------- reference model ----------------
  function automatic logic [3:0] gray_of(int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  // Decode a Gray word by searching for the value whose Gray code matches.
  function automatic int decode_gray(logic [3:0] g);
    for (int v = 0; v < 16; v++) begin
      if (gray_of(v) == g) return v;
    end
    return 0;
  endfunction

  function automatic logic exp_tc(int i);
    return up_down ? (mcnt[i] == mmax[i]) : (mcnt[i] == 0);
  endfunction

  task automatic model_edge();
    int lv;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        mcnt[i] = 0;
        movf[i] = 1'b0;
      end else if (clear) begin
        mcnt[i] = 0;
        movf[i] = 1'b0;
      end else if (preset) begin
        lv = (mlg[i] != 0) ? decode_gray(d_in) : int'(d_in);
        mcnt[i] = (lv > mmax[i]) ? mmax[i] : lv;
      end else if (en && up_down) begin
        if (mcnt[i] == mmax[i]) begin
          mcnt[i] = (mwrap[i] != 0) ? 0 : mmax[i];
          movf[i] = 1'b1;
        end else begin
          mcnt[i] = mcnt[i] + 1;
        end
      end else if (en) begin
        if (mcnt[i] == 0) begin
          mcnt[i] = (mwrap[i] != 0) ? mmax[i] : 0;
          movf[i] = 1'b1;
        end else begin
          mcnt[i] = mcnt[i] - 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(logic c, logic p, logic e, logic u, logic [3:0] d);
    clear = c; preset = p; en = e; up_down = u; d_in = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 0, 0, 0, 4'd0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      n_checks++;
      if (bin_o[i] !== 4'd0 || gray_o[i] !== 4'd0 || ovf_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got bin=%0d gray=%b ovf=%b, want 0 0000 0", i, bin_o[i], gray_o[i], ovf_o[i]);
      end
      n_checks++;
      if (tc_o[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_tc[%0d]: got %b, want 1", i, tc_o[i]);
      end
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_up_count();
    logic [3:0] prev_gray;
    drive(0, 0, 1, 1, 4'd0);
    prev_gray = gray_o[0];
    for (int k = 1; k <= 17; k++) begin
      step();
      n_checks++;
      if (bin_o[0] !== 4'(k % 16) || ovf_o[0] !== (k >= 16)) begin
        n_fail++;
        $display("FAIL up_count k=%0d: got bin=%0d ovf=%b, want bin=%0d ovf=%b", k, bin_o[0], ovf_o[0], k % 16, k >= 16);
      end
      n_checks++;
      if ($countones(gray_o[0] ^ prev_gray) != 1) begin
        n_fail++;
        $display("FAIL gray_one_bit k=%0d: got %b -> %b, want one bit changed", k, prev_gray, gray_o[0]);
      end
      prev_gray = gray_o[0];
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (bin_o[i] !== 4'(mcnt[i]) || gray_o[i] !== gray_of(mcnt[i]) || ovf_o[i] !== movf[i]) begin
          n_fail++;
          $display("FAIL up_model[%0d] k=%0d: got bin=%0d gray=%b ovf=%b, want bin=%0d gray=%b ovf=%b",
                   i, k, bin_o[i], gray_o[i], ovf_o[i], mcnt[i], gray_of(mcnt[i]), movf[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_down();
    logic [3:0] e;
    drive(1, 0, 0, 0, 4'd0);
    step();
    drive(0, 1, 0, 0, 4'd2);
    step();
    exp_q = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    drive(0, 0, 1, 0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      e = exp_q.pop_front();
      n_checks++;
      if (bin_o[1] !== e || tc_o[1] !== (e == 4'd0) || ovf_o[1] !== (k >= 3)) begin
        n_fail++;
        $display("FAIL wrap_down k=%0d: got bin=%0d tc=%b ovf=%b, want bin=%0d tc=%b ovf=%b",
                 k, bin_o[1], tc_o[1], ovf_o[1], e, e == 4'd0, k >= 3);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (bin_o[i] !== 4'(mcnt[i]) || gray_o[i] !== gray_of(mcnt[i]) || ovf_o[i] !== movf[i]) begin
          n_fail++;
          $display("FAIL down_model[%0d] k=%0d: got bin=%0d ovf=%b, want bin=%0d ovf=%b",
                   i, k, bin_o[i], ovf_o[i], mcnt[i], movf[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 1, 4'd0);
    step();
    drive(0, 1, 0, 1, 4'd8);
    step();
    n_checks++;
    if (bin_o[2] !== 4'd8 || ovf_o[2] !== 1'b0 || tc_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_preset: got bin=%0d ovf=%b tc=%b, want 8 0 0", bin_o[2], ovf_o[2], tc_o[2]);
    end
    drive(0, 0, 1, 1, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (bin_o[2] !== 4'd9 || ovf_o[2] !== (k >= 2) || tc_o[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL saturate k=%0d: got bin=%0d ovf=%b tc=%b, want bin=9 ovf=%b tc=1",
                 k, bin_o[2], ovf_o[2], tc_o[2], k >= 2);
      end
    end
  endtask

  task automatic test_gray_load();
    drive(0, 1, 0, 1, 4'b1101);
    step();
    n_checks++;
    if (bin_o[3] !== 4'd9 || gray_o[3] !== 4'b1101 || bin_o[0] !== 4'd13) begin
      n_fail++;
      $display("FAIL gray_load_9: got bin3=%0d gray3=%b bin0=%0d, want 9 1101 13", bin_o[3], gray_o[3], bin_o[0]);
    end
    n_checks++;
    if (ovf_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL preset_keeps_ovf: got %b, want 1", ovf_o[2]);
    end
    drive(0, 1, 0, 1, 4'b1000);
    step();
    n_checks++;
    if (bin_o[3] !== 4'd9 || bin_o[0] !== 4'd8 || bin_o[1] !== 4'd8) begin
      n_fail++;
      $display("FAIL gray_load_clamp: got bin3=%0d bin0=%0d bin1=%0d, want 9 8 8", bin_o[3], bin_o[0], bin_o[1]);
    end
    drive(0, 1, 0, 1, 4'b0110);
    step();
    n_checks++;
    if (bin_o[3] !== 4'd4 || bin_o[1] !== 4'd6) begin
      n_fail++;
      $display("FAIL gray_load_4: got bin3=%0d bin1=%0d, want 4 6", bin_o[3], bin_o[1]);
    end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 1, 4'd5);
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bin_o[i] !== 4'd0 || ovf_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_wins[%0d]: got bin=%0d ovf=%b, want 0 0", i, bin_o[i], ovf_o[i]);
      end
    end
    drive(0, 1, 1, 1, 4'd5);
    step();
    n_checks++;
    if (bin_o[0] !== 4'd5 || bin_o[2] !== 4'd5 || bin_o[3] !== 4'd6) begin
      n_fail++;
      $display("FAIL preset_wins: got bin0=%0d bin2=%0d bin3=%0d, want 5 5 6", bin_o[0], bin_o[2], bin_o[3]);
    end
    drive(0, 0, 0, 1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (bin_o[i] !== 4'(mcnt[i]) || ovf_o[i] !== movf[i]) begin
          n_fail++;
          $display("FAIL hold[%0d] k=%0d: got bin=%0d ovf=%b, want bin=%0d ovf=%b", i, k, bin_o[i], ovf_o[i], mcnt[i], movf[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 1, 4'd0);
    step();
    drive(0, 1, 0, 1, 4'd9);
    step();
    drive(0, 0, 1, 1, 4'd0);
    repeat (8) step();
    n_checks++;
    if (bin_o[1] !== 4'd7 || ovf_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async: got bin=%0d ovf=%b, want 7 1", bin_o[1], ovf_o[1]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      n_checks++;
      if (bin_o[i] !== 4'd0 || gray_o[i] !== 4'd0 || ovf_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got bin=%0d gray=%b ovf=%b, want 0 0000 0", i, bin_o[i], gray_o[i], ovf_o[i]);
      end
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bin_o[i] !== 4'd1 || gray_o[i] !== 4'b0001 || ovf_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL resume[%0d]: got bin=%0d gray=%b ovf=%b, want 1 0001 0", i, bin_o[i], gray_o[i], ovf_o[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      #1;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (tc_o[i] !== exp_tc(i)) begin
          n_fail++;
          $display("FAIL rand_tc[%0d] c=%0d: got %b, want %b (count %0d up_down %b)", i, c, tc_o[i], exp_tc(i), mcnt[i], up_down);
        end
      end
      step();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (bin_o[i] !== 4'(mcnt[i]) || gray_o[i] !== gray_of(mcnt[i]) || ovf_o[i] !== movf[i]) begin
          n_fail++;
          $display("FAIL rand_model[%0d] c=%0d: got bin=%0d gray=%b ovf=%b, want bin=%0d gray=%b ovf=%b",
                   i, c, bin_o[i], gray_o[i], ovf_o[i], mcnt[i], gray_of(mcnt[i]), movf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap_down();
    test_saturate();
    test_gray_load();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
